click_encoder: RTL and testbench

//  Upstream input stage of the button-check stage.

---
 rtl/click_encoder.sv | 135 +++++++++++++
 tb/tb_click_encoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/click_encoder.sv
// Pushbutton front end: two-flop sync, debounce, one-shot 3-bit click encoder.
// Optional build macro MULTI_PRESS_ERR_EN: a stable multi-button press emits code 7.
module click_encoder #(
  parameter int NUM_BTN    = 6,
  parameter int DEB_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               arm,
  output logic [2:0]         click,
  output logic               held
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    DEB,
    EMIT,
    HOLD,
    REL
  } state_t;

  state_t             state_reg, state_next;
  logic [NUM_BTN-1:0] sync_reg;
  logic [NUM_BTN-1:0] bs_reg;
  logic [NUM_BTN-1:0] pv_reg, pv_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic [2:0]         click_reg, click_next;
  logic               bs_zero;
  logic               bs_same;

  function automatic logic is_onehot(input logic [NUM_BTN-1:0] v);
    return (v != '0) && ((v & (v - NUM_BTN'(1))) == '0);
  endfunction

  function automatic logic [2:0] encode(input logic [NUM_BTN-1:0] v);
    logic [2:0] code;
    code = 3'd0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (v[i]) code = 3'(i + 1);
    end
    return code;
  endfunction

  function automatic logic [2:0] code_of(input logic [NUM_BTN-1:0] v);
    logic [2:0] code;
    if (is_onehot(v)) begin
      code = encode(v);
    end else begin
`ifdef MULTI_PRESS_ERR_EN
      code = 3'd7;
`else
      code = 3'd0;
`endif
    end
    return code;
  endfunction

  assign bs_zero = (bs_reg == '0);
  assign bs_same = (bs_reg == pv_reg);
  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg  <= '0;
      bs_reg    <= '0;
      state_reg <= IDLE;
      pv_reg    <= '0;
      cnt_reg   <= '0;
      click_reg <= 3'd0;
    end else begin
      sync_reg  <= btn;
      bs_reg    <= sync_reg;
      state_reg <= state_next;
      pv_reg    <= pv_next;
      cnt_reg   <= cnt_next;
      click_reg <= click_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pv_next    = pv_reg;
    cnt_next   = '0;
    click_next = 3'd0;
    case (state_reg)
      IDLE: begin
        if (!bs_zero) begin
          pv_next    = bs_reg;
          state_next = DEB;
        end
      end
      DEB: begin
        if (bs_zero) begin
          state_next = IDLE;
        end else if (!bs_same) begin
          pv_next = bs_reg;
        end else if (cnt_reg == CNT_LAST) begin
          // Code is registered on entry so it is visible exactly during EMIT.
          state_next = EMIT;
          click_next = arm ? code_of(pv_reg) : 3'd0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      EMIT: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (bs_zero) state_next = REL;
      end
      REL: begin
        if (!bs_zero) begin
          state_next = HOLD;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign click = click_reg;
  assign held  = (state_reg == EMIT) || (state_reg == HOLD) || (state_reg == REL);

endmodule

// File: tb/tb_click_encoder.sv
// Scoreboard bench for click_encoder (NUM_BTN=6, DEB_CYCLES=4); honours MULTI_PRESS_ERR_EN.
module tb_click_encoder;

  localparam int NB  = 6;
  localparam int DC  = 4;
  localparam int LAT = DC + 3;  // drive -> sync(2) -> first FSM sample -> DC more edges

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          arm = 1'b1;
  logic [NB-1:0] btn = '0;
  logic [2:0]    click;
  logic          held;

  typedef struct {
    logic [2:0] code;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  click_encoder #(.NUM_BTN(NB), .DEB_CYCLES(DC)) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .arm  (arm),
    .click(click),
    .held (held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_click(input logic [2:0] code);
    exp_t e;
    e.code = code;
    e.at   = cyc + LAT;
    sb.push_back(e);
    $display("queued click=%0d for cycle %0d", code, e.at);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Output monitor: every nonzero click must match the head of the scoreboard.
  initial begin
    exp_t       e;
    logic [2:0] prev;
    prev = 3'd0;
    forever begin
      @(negedge clk);
      if (click != 3'd0) begin
        check("click_gap", 32'(prev), 0);
        if (sb.size() == 0) begin
          check("unexpected_click", 32'(click), 0);
        end else begin
          e = sb.pop_front();
          $display("observed click=%0d at cycle %0d (expected %0d at %0d)", click, cyc, e.code, e.at);
          check("click_code", 32'(click), 32'(e.code));
          check("click_cycle", cyc, e.at);
        end
      end
      prev = click;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_click", 32'(click), 0);
    check("rst_held", 32'(held), 0);
    #1 rst = 1'b0;
    tick(3);

    // T1 single press of btn[2]
    btn = 6'b000100;
    expect_click(3'd3);
    tick(10);
    check("t1_held_press", 32'(held), 1);
    tick(10);
    btn = '0;
    tick(5);
    check("t1_held_rel", 32'(held), 1);
    tick(5);
    check("t1_idle", 32'(held), 0);
    tick(10);

    // T2 bounce, then stable btn[0]
    repeat (3) begin
      btn = 6'b000001;
      tick(2);
      btn = '0;
      tick(2);
    end
    btn = 6'b000001;
    expect_click(3'd1);
    tick(12);
    btn = '0;
    tick(20);

    // T3 disarmed press of btn[5], armed mid-hold, then an armed press
    arm = 1'b0;
    btn = 6'b100000;
    tick(10);
    arm = 1'b1;
    tick(5);
    check("t3_held", 32'(held), 1);
    btn = '0;
    tick(20);
    btn = 6'b100000;
    expect_click(3'd6);
    tick(12);
    btn = '0;
    tick(20);

    // T4 multi-button press
    btn = 6'b000011;
`ifdef MULTI_PRESS_ERR_EN
    expect_click(3'd7);
`endif
    tick(9);
    check("t4_held", 32'(held), 1);
    tick(1);
    btn = '0;
    tick(20);

    // T5 reset during debounce
    btn = 6'b001000;
    tick(4);
    #2 rst = 1'b1;
    #1;
    check("t5_deb_click", 32'(click), 0);
    check("t5_deb_held", 32'(held), 0);
    @(negedge clk);
    btn = '0;
    tick(2);
    rst = 1'b0;
    tick(20);

    // T5 reset during hold
    btn = 6'b001000;
    expect_click(3'd4);
    tick(10);
    check("t5_hold_before", 32'(held), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_hold_click", 32'(click), 0);
    check("t5_hold_held", 32'(held), 0);
    @(negedge clk);
    btn = '0;
    tick(2);
    rst = 1'b0;
    tick(20);

    // T6 one-cycle blip during release
    btn = 6'b000010;
    expect_click(3'd2);
    tick(12);
    btn = '0;
    tick(3);
    btn = 6'b000010;
    tick(1);
    btn = '0;
    tick(5);
    check("t6_held_after_blip", 32'(held), 1);
    tick(7);
    check("t6_idle", 32'(held), 0);
    tick(5);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
